// File: rtl/ring_osc_meter.sv
// Ring oscillator controller and frequency meter: gates the oscillator on, synchronises
// its output, counts rising edges over a programmable window, and hands off via valid/ack.
module ring_osc_meter #(
  parameter int WARMUP_CYCLES = 16,
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  input  logic              ack
);

  // Cycle counter must hold both the warmup reload and any gate reload.
  localparam int WU_W  = $clog2(WARMUP_CYCLES + 1);
  localparam int CYC_W = (GATE_W > WU_W) ? GATE_W : WU_W;
  localparam logic [CYC_W-1:0] WARMUP_LOAD = CYC_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [GATE_W-1:0] gate_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              osc_en_q;
  logic              busy_q;
  logic              valid_q;
  logic              s1_q, s2_q, s3_q;

  logic [GATE_W-1:0] gate_d;
  logic [GATE_W-1:0] gate_m1;
  logic              rise;
  logic              cyc_zero;
  logic              cnt_full;

  always_comb begin
    gate_d   = (gate_len == '0) ? GATE_W'(1) : gate_len;
    gate_m1  = gate_q - GATE_W'(1);
    rise     = s2_q & ~s3_q;
    cyc_zero = (cyc_q == '0);
    cnt_full = &cnt_q;
  end

  // Free-running synchroniser plus history flop; runs regardless of state.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= osc_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      cyc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      osc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (abort) begin
      state_q  <= IDLE;
      osc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            gate_q   <= gate_d;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= WARMUP_LOAD;
            state_q  <= WARMUP;
            osc_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        WARMUP: begin
          if (cyc_zero) begin
            cyc_q   <= CYC_W'(gate_m1);
            state_q <= MEASURE;
          end else begin
            cyc_q <= cyc_q - CYC_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            if (cnt_full) ovf_q <= 1'b1;
            else          cnt_q <= cnt_q + CNT_W'(1);
          end
          if (cyc_zero) begin
            state_q  <= DONE;
            osc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q - CYC_W'(1);
          end
        end
        DONE: begin
          if (ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          osc_en_q <= 1'b0;
          busy_q   <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign osc_en = osc_en_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign count  = cnt_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Bench for ring_osc_meter: a 16-bit-count instance and a 4-bit-count instance share stimulus;
// expected results are queued at start and checked when valid appears.
module tb_ring_osc_meter;

  localparam int WU = 16;

  logic        clk = 1'b0;
  logic        resetq;
  logic        start, abort, ack, osc_in;
  logic [15:0] gate_len;
  logic        osc_en, busy, valid, ovf;
  logic [15:0] count;
  logic        osc_en2, busy2, valid2, ovf2;
  logic [3:0]  count2;

  int total = 0;
  int bad   = 0;
  int osc_half = 0;
  bit sel = 1'b0;

  typedef struct { int lo; int hi; bit ovf; int lat; } exp_t;
  exp_t sb[$];

  logic        o_valid, o_busy, o_osc, o_ovf;
  logic [15:0] o_count;
  assign o_valid = sel ? valid2   : valid;
  assign o_busy  = sel ? busy2    : busy;
  assign o_osc   = sel ? osc_en2  : osc_en;
  assign o_ovf   = sel ? ovf2     : ovf;
  assign o_count = sel ? {12'b0, count2} : count;

  ring_osc_meter #(.WARMUP_CYCLES(WU), .GATE_W(16), .CNT_W(16)) dut (
    .clk(clk), .resetq(resetq), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en), .busy(busy), .valid(valid), .count(count),
    .ovf(ovf), .ack(ack));

  ring_osc_meter #(.WARMUP_CYCLES(WU), .GATE_W(16), .CNT_W(4)) dut_sat (
    .clk(clk), .resetq(resetq), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en2), .busy(busy2), .valid(valid2), .count(count2),
    .ovf(ovf2), .ack(ack));

  always #5 clk = ~clk;

  // Oscillator model: toggles every osc_half clocks, off the clock edge; 0 holds it low.
  initial begin
    int ph;
    ph = 0;
    osc_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (osc_half == 0) begin
        osc_in = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= osc_half) begin
          osc_in = ~osc_in;
          ph = 0;
        end
      end
    end
  end

  task automatic measure(input string name, input bit use_sat, input logic [15:0] gate,
                         input int lo, input int hi, input bit eovf,
                         input int p1, input int p2, input bit do_ack);
    exp_t e;
    int n, busy_n, osc_n;
    logic [15:0] held;
    sel = use_sat;
    e.lo = lo; e.hi = hi; e.ovf = eovf;
    e.lat = 1 + WU + ((gate == 16'd0) ? 1 : int'(gate));
    @(posedge clk); #1;
    gate_len = gate;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; busy_n = 0; osc_n = 0;
    while (!o_valid && n < 3000) begin
      if (o_busy) busy_n++;
      if (o_osc) osc_n++;
      start = (n == p1 || n == p2);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat); end
    total++;
    if (busy_n !== e.lat - 1) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, e.lat - 1); end
    total++;
    if (osc_n !== e.lat - 1) begin bad++; $display("FAIL %s osc_en_cycles: got %0d want %0d", name, osc_n, e.lat - 1); end
    total++;
    if (o_busy !== 1'b0 || o_osc !== 1'b0) begin
      bad++; $display("FAIL %s done_outputs: busy=%b osc_en=%b want 0 0", name, o_busy, o_osc);
    end
    total++;
    if (int'(o_count) < e.lo || int'(o_count) > e.hi) begin
      bad++; $display("FAIL %s count: got %0d want %0d..%0d", name, o_count, e.lo, e.hi);
    end
    total++;
    if (o_ovf !== e.ovf) begin bad++; $display("FAIL %s ovf: got %b want %b", name, o_ovf, e.ovf); end
    held = o_count;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (o_valid !== 1'b1 || o_count !== held) begin
      bad++; $display("FAIL %s hold: valid=%b count=%0d want 1 %0d", name, o_valid, o_count, held);
    end
    if (do_ack) begin
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL %s after_ack: valid=%b busy=%b want 0 0", name, o_valid, o_busy);
      end
    end
  endtask

  task automatic test_reset();
    resetq = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0; gate_len = '0;
    repeat (3) @(posedge clk);
    #3 resetq = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({osc_en, busy, valid, ovf} !== 4'b0000 || count !== 16'd0) begin
      bad++; $display("FAIL reset_state: osc_en=%b busy=%b valid=%b ovf=%b count=%0d want all 0",
                      osc_en, busy, valid, ovf, count);
    end
    total++;
    if ({osc_en2, busy2, valid2, ovf2} !== 4'b0000 || count2 !== 4'd0) begin
      bad++; $display("FAIL reset_state_sat: got %b%b%b%b count=%0d want all 0",
                      osc_en2, busy2, valid2, ovf2, count2);
    end
  endtask

  task automatic test_square();
    osc_half = 4;
    repeat (10) @(posedge clk);
    measure("square", 1'b0, 16'd800, 99, 101, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_ignored();
    sel = 1'b0;
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ack_in_idle: valid=%b busy=%b want 0 0", valid, busy);
    end
    measure("clean40", 1'b0, 16'd40, 5, 5, 1'b0, 0, 0, 1'b1);
    measure("restart40", 1'b0, 16'd40, 5, 5, 1'b0, 3, WU + 10, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || osc_en !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL start_with_abort: busy=%b osc_en=%b valid=%b want 0 0 0", busy, osc_en, valid);
    end
  endtask

  task automatic test_zero_gate();
    osc_half = 0;
    repeat (5) @(posedge clk);
    measure("zero_gate", 1'b0, 16'd0, 0, 0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_abort();
    int vseen;
    sel = 1'b0;
    osc_half = 4;
    @(posedge clk); #1;
    gate_len = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WU + 8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (osc_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL abort_measure: osc_en=%b busy=%b valid=%b want 0 0 0", osc_en, busy, valid);
    end
    vseen = 0;
    repeat (80) begin @(posedge clk); #1; if (valid) vseen++; end
    total++;
    if (vseen !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", vseen); end
    osc_half = 0;
    repeat (5) @(posedge clk);
    measure("pre_abort_done", 1'b0, 16'd4, 0, 0, 1'b0, 0, 0, 1'b0);
    abort = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; ack = 1'b0;
    total++;
    if (osc_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL abort_done: osc_en=%b busy=%b valid=%b want 0 0 0", osc_en, busy, valid);
    end
  endtask

  task automatic test_saturation();
    osc_half = 2;
    repeat (10) @(posedge clk);
    measure("saturate", 1'b1, 16'd100, 15, 15, 1'b1, 0, 0, 1'b1);
    osc_half = 0;
    repeat (6) @(posedge clk);
    measure("after_sat", 1'b1, 16'd20, 0, 0, 1'b0, 0, 0, 1'b1);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    osc_half = 4;
    @(posedge clk); #1;
    gate_len = 16'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WU + 40) @(posedge clk);
    #3 resetq = 1'b0;
    #1;
    total++;
    if ({osc_en, busy, valid, ovf} !== 4'b0000 || count !== 16'd0) begin
      bad++; $display("FAIL reset_mid: osc_en=%b busy=%b valid=%b ovf=%b count=%0d want all 0",
                      osc_en, busy, valid, ovf, count);
    end
    @(posedge clk);
    #3 resetq = 1'b1;
    repeat (3) @(posedge clk);
    measure("square_after_reset", 1'b0, 16'd800, 99, 101, 1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_square();
    test_ignored();
    test_zero_gate();
    test_abort();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Controller and frequency meter for the on-chip LUT ring oscillator. It enables the oscillator only while a measurement runs. It synchronises the free-running oscillator output into the system clock domain and counts its rising edges over a programmable gate window. The result is delivered through a valid/ack handshake. It sits between the ring oscillator instance and the CPU's I/O register block, which uses it for entropy harvesting and process/temperature monitoring.

## Interface

Parameters:
- `WARMUP_CYCLES`, 16: clk cycles the oscillator runs before counting starts; must be ≥ 1.
- `GATE_W`, 16: width of the gate-length input and the gate counter.
- `CNT_W`, 16: width of the edge-count result.

Ports:
- `clk`, input, 1: system clock; all state is on the rising edge.
- `resetq`, input, 1: reset, asynchronous and active-low; clears all state.
- `start`, input, 1: request a measurement; sampled only in IDLE.
- `abort`, input, 1: cancel any measurement or pending result.
- `gate_len`, input, GATE_W: gate window in clk cycles; latched when `start` is accepted.
- `osc_in`, input, 1: raw ring oscillator output; asynchronous to `clk`.
- `osc_en`, output, 1: oscillator enable; drives the oscillator's `resetq`.
- `busy`, output, 1: high in WARMUP and MEASURE.
- `valid`, output, 1: result available; high in DONE.
- `count`, output, CNT_W: number of rising edges counted during the gate window.
- `ovf`, output, 1: the edge count saturated during the gate window.
- `ack`, input, 1: consumer accepted the result; sampled only in DONE.

## Operation

States are IDLE, WARMUP, MEASURE and DONE. Reset puts the block in IDLE.

- **IDLE**
  - `start`=1 and `abort`=0: latch `gate_len` into `gate_q`; a value of 0 is latched as 1. Clear the edge counter and `ovf`. Load `WARMUP_CYCLES-1` into the cycle counter. Go to WARMUP.
  - Otherwise stay in IDLE.
- **WARMUP**: `osc_en`=1. Decrement the cycle counter. When it reaches 0, load `gate_q-1` and go to MEASURE.
- **MEASURE**: `osc_en`=1. Count synchronised rising edges. Decrement the cycle counter. When it reaches 0, go to DONE.
- **DONE**: `osc_en`=0, `valid`=1. `count` and `ovf` are held stable. `ack`=1 returns the block to IDLE.
- **Abort**: `abort`=1 in any state sends the block to IDLE on the next edge. `osc_en` and `valid` drop, and no result is delivered. `abort` has priority over `start` and `ack`.
- **Synchroniser and edge detector**
  - `osc_in` passes through a two-flop synchroniser (s1, s2) and a history flop s3.
  - A rising edge is s2=1 and s3=0.
  - The synchroniser runs every cycle, independent of state.
- **Counting**
  - Increment only in MEASURE when a rising edge is detected, including in the last MEASURE cycle.
  - At all-ones the counter holds and `ovf` sets; `ovf` stays set until the next accepted `start`.
- **Measurable range**: the oscillator frequency must be below fclk/2 to be measured correctly. Faster oscillators alias; this is documented and not flagged.
- **Ignored inputs**: `start` outside IDLE and `ack` outside DONE have no effect.
- **Output values by state**
  - `count` shows the live counter in every state, but is only meaningful while `valid`=1.
  - After reset: `osc_en`=0, `busy`=0, `valid`=0, `count`=0, `ovf`=0. s1, s2 and s3 are cleared.

## Timing

- `start` is accepted at edge t. From t+1 the block is in WARMUP with `osc_en`=1 and `busy`=1.
- WARMUP lasts exactly `WARMUP_CYCLES` cycles; MEASURE lasts exactly `gate_q` cycles.
- `valid` rises at edge t+1+`WARMUP_CYCLES`+`gate_q`. On the same edge `busy` and `osc_en` fall.
- `ack` seen at edge u in DONE: from u+1 the block is in IDLE with `valid`=0. A new `start` can be accepted at u+1.
- Edge-detect latency is 3 cycles from `osc_in` to the rising-edge strobe. Edges in the last 2 gate cycles may be missed, and edges from the last 2 warmup cycles may be counted. This bias is accepted.
- `abort` seen at edge a: from a+1 the block is in IDLE with `osc_en`=0, `busy`=0 and `valid`=0.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan

- **Square-wave measurement.** Stimulus: `osc_in` toggles every 4 clk (period 8), `WARMUP_CYCLES`=16, `gate_len`=800, pulse `start`.
  - `busy` is high for 816 cycles.
  - `valid` rises 817 cycles after the start edge, with `count`=100±1 and `ovf`=0.
  - `valid` holds until `ack`, then drops one cycle later.
- **Zero gate length.** Stimulus: `gate_len`=0.
  - MEASURE lasts 1 cycle.
  - `valid` rises at t+1+16+1.
  - With `osc_in` held at 0, `count`=0.
- **Saturation.** Stimulus: `CNT_W`=4, `osc_in` period 4 clk, `gate_len`=100.
  - `count`=15 and `ovf`=1.
  - A following measurement with `osc_in`=0 gives `count`=0 and `ovf`=0.
- **Abort.** Stimulus: assert `abort` during MEASURE; then assert `abort` and `ack` together in DONE.
  - Both cases: next cycle the block is in IDLE with `osc_en`=0, `valid`=0 and `busy`=0.
  - No `valid` pulse occurs.
- **Ignored inputs.** Stimulus: pulse `start` during WARMUP and MEASURE, and pulse `ack` in IDLE.
  - Timing and `count` are unchanged versus a clean run.
  - `start` together with `abort` in IDLE leaves the block in IDLE.
- **Reset mid-measurement.** Stimulus: drive `resetq` low between clock edges during MEASURE.
  - `osc_en`, `busy`, `valid`, `count` and `ovf` go to 0 immediately.
  - After release, the next `start` behaves as in the first scenario.
